// File: rtl/DH_pkg.sv
// Shared definitions for the duck-hunt game controller: state encoding,
// default tuning constants and a saturating score adder.
package DH_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READY,
        S_FLY,
        S_FALL,
        S_ESCAPE,
        S_ROUND_END,
        S_GAME_OVER
    } state_e;

    localparam int DEF_DUCKS_PER_ROUND = 10;
    localparam int DEF_SHOTS_PER_DUCK  = 3;
    localparam int DEF_PASS_HITS       = 6;
    localparam int DEF_MAX_ROUND       = 9;
    localparam int DEF_READY_FRAMES    = 120;
    localparam int DEF_FLY_FRAMES      = 600;
    localparam int DEF_HIT_POINTS      = 500;

    localparam int TIMER_W = 16;

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/ctl_game_frame_timer.sv
// Counts new_frame pulses since the last clear; done flags the pulse that
// reaches the limit, so the owner can react on that same edge.
module ctl_game_frame_timer
    import DH_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               new_frame,
    input  logic [TIMER_W-1:0] limit,
    output logic               done
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;
    logic [TIMER_W:0]   count_next;

    assign count_next = {1'b0, count_q} + {{TIMER_W{1'b0}}, 1'b1};
    assign done       = new_frame && (count_next >= {1'b0, limit});

    // Saturate instead of wrapping so a long idle period cannot alias a limit.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (new_frame && !(&count_q)) begin
            count_d = count_next[TIMER_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ctl_game.sv
// Duck-hunt game sequencer: paces ducks, tracks shots, hits, rounds and score,
// and tells the duck engine when to launch and when to flee.
module ctl_game
    import DH_pkg::*;
#(
    parameter int DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
    parameter int SHOTS_PER_DUCK  = DEF_SHOTS_PER_DUCK,
    parameter int PASS_HITS       = DEF_PASS_HITS,
    parameter int MAX_ROUND       = DEF_MAX_ROUND,
    parameter int READY_FRAMES    = DEF_READY_FRAMES,
    parameter int FLY_FRAMES      = DEF_FLY_FRAMES,
    parameter int HIT_POINTS      = DEF_HIT_POINTS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       new_frame,
    input  logic                       start,
    input  logic                       hit,
    input  logic                       miss,
    input  logic                       duck_escaped,
    input  logic                       duck_fall_done,
    output logic                       duck_launch,
    output logic                       duck_flee,
    output logic                       duck_hit,
    output logic [1:0]                 shots_left,
    output logic [3:0]                 duck_idx,
    output logic [DUCKS_PER_ROUND-1:0] hit_mask,
    output logic [3:0]                 hit_count,
    output logic [3:0]                 round,
    output logic [15:0]                score,
    output logic                       game_over,
    output logic                       game_won
);

    localparam logic [DUCKS_PER_ROUND-1:0] MASK_ONE = DUCKS_PER_ROUND'(1);
    localparam logic [3:0]                 LAST_DUCK = 4'(DUCKS_PER_ROUND - 1);

    state_e                     state_q, state_d;
    logic                       launch_q, launch_d;
    logic                       flee_q, flee_d;
    logic                       duck_hit_q, duck_hit_d;
    logic [1:0]                 shots_q, shots_d;
    logic [3:0]                 idx_q, idx_d;
    logic [DUCKS_PER_ROUND-1:0] mask_q, mask_d;
    logic [3:0]                 count_q, count_d;
    logic [3:0]                 round_q, round_d;
    logic [15:0]                score_q, score_d;
    logic                       over_q, over_d;
    logic                       won_q, won_d;

    logic                       resolve;
    logic                       timer_clear;
    logic                       timer_done;
    logic [TIMER_W-1:0]         timer_limit;

    assign timer_limit = (state_q == S_FLY) ? TIMER_W'(FLY_FRAMES) : TIMER_W'(READY_FRAMES);
    assign timer_clear = (state_d != state_q);

    ctl_game_frame_timer u_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (timer_clear),
        .new_frame (new_frame),
        .limit     (timer_limit),
        .done      (timer_done)
    );

    always_comb begin
        state_d  = state_q;
        launch_d = 1'b0;
        flee_d   = 1'b0;
        shots_d  = shots_q;
        idx_d    = idx_q;
        mask_d   = mask_q;
        count_d  = count_q;
        round_d  = round_q;
        score_d  = score_q;
        won_d    = won_q;
        resolve  = 1'b0;

        unique case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    score_d = '0;
                    mask_d  = '0;
                    count_d = '0;
                    idx_d   = '0;
                    won_d   = 1'b0;
                    round_d = 4'd1;
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (timer_done) begin
                    launch_d = 1'b1;
                    shots_d  = 2'(SHOTS_PER_DUCK);
                    state_d  = S_FLY;
                end
            end
            // Event priority is hit > escaped > miss > timeout, so a hit on
            // the last shot still drops the duck.
            S_FLY: begin
                if (hit) begin
                    mask_d  = mask_q | (MASK_ONE << idx_q);
                    count_d = count_q + 4'd1;
                    score_d = sat_add16(score_q, 16'(HIT_POINTS));
                    if (shots_q != 2'd0) begin
                        shots_d = shots_q - 2'd1;
                    end
                    state_d = S_FALL;
                end else if (duck_escaped) begin
                    resolve = 1'b1;
                end else if (miss) begin
                    if (shots_q != 2'd0) begin
                        shots_d = shots_q - 2'd1;
                    end
                    if (shots_d == 2'd0) begin
                        flee_d  = 1'b1;
                        state_d = S_ESCAPE;
                    end
                end else if (timer_done) begin
                    flee_d  = 1'b1;
                    state_d = S_ESCAPE;
                end
            end
            S_FALL: begin
                resolve = duck_fall_done;
            end
            S_ESCAPE: begin
                resolve = duck_escaped;
            end
            S_ROUND_END: begin
                if (timer_done) begin
                    if (count_q < 4'(PASS_HITS)) begin
                        won_d   = 1'b0;
                        state_d = S_GAME_OVER;
                    end else if (round_q == 4'(MAX_ROUND)) begin
                        won_d   = 1'b1;
                        state_d = S_GAME_OVER;
                    end else begin
                        round_d = round_q + 4'd1;
                        mask_d  = '0;
                        count_d = '0;
                        idx_d   = '0;
                        state_d = S_READY;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (resolve) begin
            if (idx_q == LAST_DUCK) begin
                state_d = S_ROUND_END;
            end else begin
                idx_d   = idx_q + 4'd1;
                state_d = S_READY;
            end
        end

        duck_hit_d = (state_d == S_FALL);
        over_d     = (state_d == S_GAME_OVER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            launch_q   <= 1'b0;
            flee_q     <= 1'b0;
            duck_hit_q <= 1'b0;
            shots_q    <= '0;
            idx_q      <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            round_q    <= 4'd1;
            score_q    <= '0;
            over_q     <= 1'b0;
            won_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            launch_q   <= launch_d;
            flee_q     <= flee_d;
            duck_hit_q <= duck_hit_d;
            shots_q    <= shots_d;
            idx_q      <= idx_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            round_q    <= round_d;
            score_q    <= score_d;
            over_q     <= over_d;
            won_q      <= won_d;
        end
    end

    assign duck_launch = launch_q;
    assign duck_flee   = flee_q;
    assign duck_hit    = duck_hit_q;
    assign shots_left  = shots_q;
    assign duck_idx    = idx_q;
    assign hit_mask    = mask_q;
    assign hit_count   = count_q;
    assign round       = round_q;
    assign score       = score_q;
    assign game_over   = over_q;
    assign game_won    = won_q;

endmodule

// File: tb/tb_ctl_game.sv
// Directed bench for ctl_game with short pauses (READY_FRAMES=2, FLY_FRAMES=8).
module tb_ctl_game;

    logic        clk;
    logic        rst;
    logic        new_frame;
    logic        start;
    logic        hit;
    logic        miss;
    logic        duck_escaped;
    logic        duck_fall_done;
    logic        duck_launch;
    logic        duck_flee;
    logic        duck_hit;
    logic [1:0]  shots_left;
    logic [3:0]  duck_idx;
    logic [9:0]  hit_mask;
    logic [3:0]  hit_count;
    logic [3:0]  round;
    logic [15:0] score;
    logic        game_over;
    logic        game_won;

    int tests  = 0;
    int failed = 0;

    ctl_game #(
        .READY_FRAMES (2),
        .FLY_FRAMES   (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .new_frame      (new_frame),
        .start          (start),
        .hit            (hit),
        .miss           (miss),
        .duck_escaped   (duck_escaped),
        .duck_fall_done (duck_fall_done),
        .duck_launch    (duck_launch),
        .duck_flee      (duck_flee),
        .duck_hit       (duck_hit),
        .shots_left     (shots_left),
        .duck_idx       (duck_idx),
        .hit_mask       (hit_mask),
        .hit_count      (hit_count),
        .round          (round),
        .score          (score),
        .game_over      (game_over),
        .game_won       (game_won)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs set before a tick are seen on the next edge and dropped #1 after it.
    task automatic tick();
        @(posedge clk);
        #1;
        new_frame      = 1'b0;
        start          = 1'b0;
        hit            = 1'b0;
        miss           = 1'b0;
        duck_escaped   = 1'b0;
        duck_fall_done = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            new_frame = 1'b1;
            tick();
        end
    endtask

    task automatic hitDuck();
        frames(2);
        hit = 1'b1;
        tick();
        duck_fall_done = 1'b1;
        tick();
    endtask

    task automatic escapeDuck();
        frames(2);
        duck_escaped = 1'b1;
        tick();
    endtask

    task automatic playRound(input int hits);
        for (int d = 0; d < 10; d++) begin
            if (d < hits) hitDuck();
            else escapeDuck();
        end
        frames(2);
    endtask

    initial begin
        rst = 1'b0;
        new_frame = 1'b0; start = 1'b0; hit = 1'b0; miss = 1'b0;
        duck_escaped = 1'b0; duck_fall_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_round", 32'(round), 32'd1);
        check("rst_score", 32'(score), 32'd0);
        check("rst_shots", 32'(shots_left), 32'd0);
        check("rst_over", 32'(game_over), 32'd0);
        rst = 1'b1;
        tick();

        start = 1'b1;
        tick();
        frames(1);
        check("launch_early", 32'(duck_launch), 32'd0);
        frames(1);
        check("launch_pulse", 32'(duck_launch), 32'd1);
        check("launch_shots", 32'(shots_left), 32'd3);
        check("launch_idx", 32'(duck_idx), 32'd0);
        tick();
        check("launch_one_cycle", 32'(duck_launch), 32'd0);

        hit = 1'b1; miss = 1'b1;
        tick();
        check("fall_duck_hit", 32'(duck_hit), 32'd1);
        check("fall_mask", 32'(hit_mask), 32'h001);
        check("fall_score", 32'(score), 32'd500);
        check("fall_shots", 32'(shots_left), 32'd2);
        check("fall_flee", 32'(duck_flee), 32'd0);
        duck_fall_done = 1'b1;
        tick();
        check("fall_done_idx", 32'(duck_idx), 32'd1);
        check("fall_done_hit", 32'(duck_hit), 32'd0);

        hit = 1'b1;
        tick();
        check("ready_hit_ignored", 32'(hit_count), 32'd1);
        start = 1'b1;
        tick();
        check("ready_start_ignored", 32'(score), 32'd500);

        frames(2);
        miss = 1'b1; tick();
        check("miss1_shots", 32'(shots_left), 32'd2);
        miss = 1'b1; tick();
        check("miss2_shots", 32'(shots_left), 32'd1);
        check("miss2_flee", 32'(duck_flee), 32'd0);
        miss = 1'b1; tick();
        check("miss3_shots", 32'(shots_left), 32'd0);
        check("miss3_flee", 32'(duck_flee), 32'd1);
        tick();
        check("flee_one_cycle", 32'(duck_flee), 32'd0);
        duck_escaped = 1'b1; tick();
        check("escape_idx", 32'(duck_idx), 32'd2);

        frames(2);
        frames(7);
        check("timeout_early", 32'(duck_flee), 32'd0);
        frames(1);
        check("timeout_flee", 32'(duck_flee), 32'd1);
        check("timeout_shots", 32'(shots_left), 32'd3);
        duck_escaped = 1'b1; tick();
        check("timeout_idx", 32'(duck_idx), 32'd3);

        frames(2);
        duck_escaped = 1'b1; miss = 1'b1;
        tick();
        check("esc_prio_idx", 32'(duck_idx), 32'd4);
        check("esc_prio_shots", 32'(shots_left), 32'd3);
        check("esc_prio_flee", 32'(duck_flee), 32'd0);

        for (int d = 4; d < 9; d++) hitDuck();
        escapeDuck();
        check("rend_count", 32'(hit_count), 32'd6);
        check("rend_mask", 32'(hit_mask), 32'h1F1);
        check("rend_round", 32'(round), 32'd1);
        frames(2);
        check("r2_round", 32'(round), 32'd2);
        check("r2_mask", 32'(hit_mask), 32'd0);
        check("r2_count", 32'(hit_count), 32'd0);
        check("r2_idx", 32'(duck_idx), 32'd0);

        playRound(5);
        check("lose_over", 32'(game_over), 32'd1);
        check("lose_won", 32'(game_won), 32'd0);
        check("lose_score", 32'(score), 32'd5500);

        start = 1'b1;
        tick();
        check("restart_score", 32'(score), 32'd0);
        check("restart_round", 32'(round), 32'd1);
        check("restart_over", 32'(game_over), 32'd0);
        for (int r = 1; r <= 9; r++) begin
            playRound(6);
            if (r < 9) check("round_adv", 32'(round), 32'(r + 1));
        end
        check("win_over", 32'(game_over), 32'd1);
        check("win_won", 32'(game_won), 32'd1);
        check("win_score", 32'(score), 32'd27000);

        start = 1'b1;
        tick();
        check("win_restart_score", 32'(score), 32'd0);
        check("win_restart_round", 32'(round), 32'd1);
        check("win_restart_won", 32'(game_won), 32'd0);

        frames(2);
        hit = 1'b1;
        tick();
        check("pre_rst_fall", 32'(duck_hit), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_duck_hit", 32'(duck_hit), 32'd0);
        check("arst_score", 32'(score), 32'd0);
        check("arst_mask", 32'(hit_mask), 32'd0);
        check("arst_count", 32'(hit_count), 32'd0);
        check("arst_shots", 32'(shots_left), 32'd0);
        check("arst_round", 32'(round), 32'd1);
        tick();
        rst = 1'b1;
        duck_fall_done = 1'b1;
        tick();
        check("post_rst_idx", 32'(duck_idx), 32'd0);
        check("post_rst_launch", 32'(duck_launch), 32'd0);
        frames(2);
        check("post_rst_no_launch", 32'(duck_launch), 32'd0);
        check("post_rst_no_flee", 32'(duck_flee), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ctl_game.md
CTL_GAME -- requirements
Module: ctl_game

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DUCKS_PER_ROUND, 10, ducks flown per round.
- SHOTS_PER_DUCK, 3, shots allowed per duck.
- PASS_HITS, 6, minimum hits to clear a round.
- MAX_ROUND, 9, last round.
- READY_FRAMES, 120, pause length in READY and ROUND_END, in frames.
- FLY_FRAMES, 600, frames in FLY before forced flee.
- HIT_POINTS, 500, score added per hit.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, main 65 MHz clock; single clock domain.
- rst, in, 1, asynchronous, active-low reset.
- new_frame, in, 1, one-cycle pulse per video frame.
- start, in, 1, one-cycle pulse requesting game start.
- hit, in, 1, one-cycle pulse: shot hit duck.
- miss, in, 1, one-cycle pulse: shot missed.
- duck_escaped, in, 1, pulse: duck left the screen.
- duck_fall_done, in, 1, pulse: shot duck reached ground.
- duck_launch, out, 1, one-cycle pulse: start a new duck flight.
- duck_flee, out, 1, one-cycle pulse: duck must fly off.
- duck_hit, out, 1, level, high for the whole FALL state.
- shots_left, out, 2, remaining shots for current duck.
- duck_idx, out, 4, index of current duck in round, 0..DUCKS_PER_ROUND-1.
- hit_mask, out, DUCKS_PER_ROUND, bit i set when duck i was hit.
- hit_count, out, 4, hits in current round.
- round, out, 4, current round, 1..MAX_ROUND.
- score, out, 16, game score, saturating.
- game_over, out, 1, high in GAME_OVER.
- game_won, out, 1, high in GAME_OVER when MAX_ROUND was cleared.

Function
REQ-003 The block SHALL implement states IDLE, READY, FLY, FALL, ESCAPE, ROUND_END, GAME_OVER.
REQ-004 IDLE or GAME_OVER plus start SHALL clear score, hit_mask, hit_count, duck_idx and game_won, set round=1, and go to READY.
REQ-005 READY SHALL count READY_FRAMES new_frame pulses, then go to FLY, asserting duck_launch for exactly one cycle on the transition and loading shots_left=SHOTS_PER_DUCK.
REQ-006 FLY, hit: go to FALL; set hit_mask[duck_idx]; increment hit_count; score += HIT_POINTS, saturating at 16'hFFFF; decrement shots_left.
REQ-007 FLY, miss: decrement shots_left; if the result is 0, pulse duck_flee and go to ESCAPE.
REQ-008 FLY, FLY_FRAMES new_frame pulses elapsed since launch: pulse duck_flee and go to ESCAPE; shots_left is unchanged.
REQ-009 FLY, duck_escaped without hit: go directly to duck-resolved handling (REQ-011) and count the duck as missed.
REQ-010 FALL SHALL wait for duck_fall_done; ESCAPE SHALL wait for duck_escaped.
REQ-011 Duck resolved: if duck_idx==DUCKS_PER_ROUND-1, go to ROUND_END; otherwise increment duck_idx and go to READY.
REQ-012 ROUND_END SHALL wait READY_FRAMES frames, then:
- hit_count<PASS_HITS: go to GAME_OVER with game_won=0.
- Pass and round==MAX_ROUND: go to GAME_OVER with game_won=1.
- Otherwise: round+1, clear hit_mask, hit_count and duck_idx, then go to READY.
REQ-013 hit, miss, duck_escaped and duck_fall_done outside the states that consume them SHALL be ignored; start outside IDLE or GAME_OVER SHALL be ignored.
REQ-014 Simultaneous events in FLY SHALL resolve with priority hit > duck_escaped > miss > timeout; a hit on the last shot goes to FALL, not ESCAPE.
REQ-015 Frame counters SHALL clear on every state entry; pause counts SHALL advance only on new_frame.
REQ-016 shots_left SHALL never decrement below 0.
REQ-017 Every output SHALL be registered; duck_launch and duck_flee SHALL be asserted in the cycle after the triggering event.

Reset
REQ-018 rst low SHALL immediately force:
- state IDLE
- duck_launch, duck_flee, duck_hit = 0
- shots_left, duck_idx, hit_mask, hit_count, score = 0
- round = 1
- game_over, game_won = 0
- frame counters = 0
REQ-019 Reset asserted mid-flight SHALL abort the game with no pulse emitted; after release the block SHALL wait for start.

Structure
REQ-020 The state enum and the default parameter constants SHALL live in the shared package DH_pkg.
REQ-021 The frame pause/timeout counter SHALL be a sub-module, ctl_game_frame_timer, with ports clear, new_frame, limit and done.

Verification
REQ-022 Bench SHALL cover these directed scenarios (with READY_FRAMES=2 and FLY_FRAMES=8):
- start, 2 frames -> duck_launch one cycle; shots_left=3; duck_idx=0.
- In FLY, miss x3 -> shots_left 2,1,0; duck_flee pulse after third miss; duck_escaped -> READY with duck_idx=1.
- In FLY, hit and miss in the same cycle -> FALL; duck_hit=1; hit_mask[0]=1; score=500; shots_left=2.
- 10 ducks with 6 hits -> ROUND_END, then round=2, hit_mask=0; 5 hits -> GAME_OVER, game_won=0.
- Round 9 passed -> game_over=1, game_won=1; start -> score=0, round=1.
- rst low during FALL -> all outputs at reset values that same cycle; a later duck_fall_done is ignored.
